// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) definitions: sizes, bit-position maps and helper
// functions for syndrome calculation, correction, data extraction and encoding.
package hamming_pkg;

  localparam int unsigned N_CODIGO   = 15;
  localparam int unsigned N_DADOS    = 11;
  localparam int unsigned N_SINDROME = 4;

  // Codeword bit index (position-1) of every data bit, LSB first
  localparam int unsigned POS_DADOS [N_DADOS] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};
  // Codeword bit index of the parity bits (positions 1, 2, 4, 8)
  localparam int unsigned POS_PARIDADE [N_SINDROME] = '{0, 1, 3, 7};

  // Syndrome = XOR of the 1-based positions of all set bits
  function automatic logic [N_SINDROME-1:0] calc_sindrome(input logic [N_CODIGO-1:0] palavra);
    logic [N_SINDROME-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < N_CODIGO; i++) begin
      if (palavra[i]) s = s ^ N_SINDROME'(i + 1);
    end
    return s;
  endfunction

  // Invert the bit at position s (index s-1); s=0 leaves the word untouched
  function automatic logic [N_CODIGO-1:0] corrige(input logic [N_CODIGO-1:0] palavra,
                                                 input logic [N_SINDROME-1:0] s);
    logic [N_CODIGO-1:0] c;
    for (int unsigned i = 0; i < N_CODIGO; i++) begin
      c[i] = palavra[i] ^ (s == N_SINDROME'(i + 1));
    end
    return c;
  endfunction

  // Gather the data bits out of a codeword
  function automatic logic [N_DADOS-1:0] extrai_dados(input logic [N_CODIGO-1:0] c);
    logic [N_DADOS-1:0] d;
    for (int unsigned k = 0; k < N_DADOS; k++) begin
      d[k] = c[POS_DADOS[k]];
    end
    return d;
  endfunction

  // Encoder: place data, then set each parity bit to zero out its syndrome bit
  function automatic logic [N_CODIGO-1:0] codifica(input logic [N_DADOS-1:0] d);
    logic [N_CODIGO-1:0]   c;
    logic [N_SINDROME-1:0] s;
    c = '0;
    for (int unsigned k = 0; k < N_DADOS; k++) begin
      c[POS_DADOS[k]] = d[k];
    end
    s = calc_sindrome(c);
    for (int unsigned k = 0; k < N_SINDROME; k++) begin
      c[POS_PARIDADE[k]] = s[k];
    end
    return c;
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational 15->4 Hamming syndrome generator.
module hamming_sindrome
  import hamming_pkg::*;
(
  input  logic [N_CODIGO-1:0]   palavra_i,
  output logic [N_SINDROME-1:0] sindrome_o
);

  // Pure XOR tree over the received word
  always_comb sindrome_o = calc_sindrome(palavra_i);

endmodule

// File: rtl/hamming_corretor.sv
// Streaming Hamming(15,11) single-error-correcting decoder, 2-stage
// valid/ready pipeline with saturating statistics counters.
// Optional macro HAMMING_SINDROME_SAIDA_EN adds the sindrome output and the
// cont_posicao_max register.
module hamming_corretor
  import hamming_pkg::*;
#(
  parameter int unsigned LARGURA_CONT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CODIGO-1:0]     entrada,
  input  logic                    entrada_valida,
  output logic                    entrada_pronta,
  output logic [N_DADOS-1:0]      saida,
  output logic                    corrigido,
  output logic                    saida_valida,
  input  logic                    saida_pronta,
  input  logic                    limpa_contadores,
  output logic [LARGURA_CONT-1:0] cont_palavras,
  output logic [LARGURA_CONT-1:0] cont_corrigidos
`ifdef HAMMING_SINDROME_SAIDA_EN
  ,
  output logic [N_SINDROME-1:0]   sindrome,
  output logic [N_SINDROME-1:0]   cont_posicao_max
`endif
);

  logic                    s1_valid_q;
  logic [N_CODIGO-1:0]     s1_palavra_q;
  logic [N_SINDROME-1:0]   s1_sind_q;
  logic [N_SINDROME-1:0]   sind_calc;

  logic                    s2_valid_q;
  logic [N_DADOS-1:0]      saida_q, saida_d;
  logic                    corrigido_q, corrigido_d;

  logic [LARGURA_CONT-1:0] cont_palavras_q, cont_palavras_d;
  logic [LARGURA_CONT-1:0] cont_corr_q, cont_corr_d;

  logic s1_pronta, s2_pronta, xfer_entrada, xfer_saida;

  hamming_sindrome u_sindrome (
    .palavra_i  (entrada),
    .sindrome_o (sind_calc)
  );

  // Ready chain is built from the valid flags only, never from entrada_valida
  always_comb begin
    s2_pronta    = !s2_valid_q || saida_pronta;
    s1_pronta    = !s1_valid_q || s2_pronta;
    xfer_entrada = entrada_valida && s1_pronta;
    xfer_saida   = s2_valid_q && saida_pronta;
  end

  // Stage-2 payload: corrected word reduced to its data bits
  always_comb begin
    saida_d     = extrai_dados(corrige(s1_palavra_q, s1_sind_q));
    corrigido_d = (s1_sind_q != '0);
  end

  // Pipeline registers; each stage reloads whenever it is ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_palavra_q <= '0;
      s1_sind_q    <= '0;
      s2_valid_q   <= 1'b0;
      saida_q      <= '0;
      corrigido_q  <= 1'b0;
    end else begin
      if (s1_pronta) begin
        s1_valid_q <= entrada_valida;
      end
      if (xfer_entrada) begin
        s1_palavra_q <= entrada;
        s1_sind_q    <= sind_calc;
      end
      if (s2_pronta) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s1_valid_q && s2_pronta) begin
        saida_q     <= saida_d;
        corrigido_q <= corrigido_d;
      end
    end
  end

  // Saturating counters; clear wins over a same-cycle increment
  always_comb begin
    cont_palavras_d = cont_palavras_q;
    cont_corr_d     = cont_corr_q;
    if (limpa_contadores) begin
      cont_palavras_d = '0;
      cont_corr_d     = '0;
    end else if (xfer_saida) begin
      if (cont_palavras_q != '1) cont_palavras_d = cont_palavras_q + LARGURA_CONT'(1);
      if (corrigido_q && (cont_corr_q != '1)) cont_corr_d = cont_corr_q + LARGURA_CONT'(1);
    end
  end

  // Counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_palavras_q <= '0;
      cont_corr_q     <= '0;
    end else begin
      cont_palavras_q <= cont_palavras_d;
      cont_corr_q     <= cont_corr_d;
    end
  end

  assign entrada_pronta  = s1_pronta;
  assign saida           = saida_q;
  assign corrigido       = corrigido_q;
  assign saida_valida    = s2_valid_q;
  assign cont_palavras   = cont_palavras_q;
  assign cont_corrigidos = cont_corr_q;

`ifdef HAMMING_SINDROME_SAIDA_EN
  logic [N_SINDROME-1:0] sind2_q;
  logic [N_SINDROME-1:0] pos_max_q;

  // Syndrome follows the stage-2 payload; max tracks delivered words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sind2_q   <= '0;
      pos_max_q <= '0;
    end else begin
      if (s1_valid_q && s2_pronta) begin
        sind2_q <= s1_sind_q;
      end
      if (limpa_contadores) begin
        pos_max_q <= '0;
      end else if (xfer_saida && (sind2_q > pos_max_q)) begin
        pos_max_q <= sind2_q;
      end
    end
  end

  assign sindrome         = sind2_q;
  assign cont_posicao_max = pos_max_q;
`endif

endmodule

// File: tb/tb_hamming_corretor.sv
// Directed, table-driven bench for hamming_corretor.
module tb_hamming_corretor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, entrada_valida, saida_pronta, limpa;
  logic [14:0] entrada;
  logic        entrada_pronta, saida_valida, corrigido;
  logic [10:0] saida;
  logic [3:0]  cp4, cc4;

  logic        entrada_pronta16, saida_valida16, corrigido16;
  logic [10:0] saida16;
  logic [15:0] cp16, cc16;

`ifdef HAMMING_SINDROME_SAIDA_EN
  logic [3:0] sind4, pmax4, sind16, pmax16;
`endif

  hamming_corretor #(.LARGURA_CONT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .entrada          (entrada),
    .entrada_valida   (entrada_valida),
    .entrada_pronta   (entrada_pronta),
    .saida            (saida),
    .corrigido        (corrigido),
    .saida_valida     (saida_valida),
    .saida_pronta     (saida_pronta),
    .limpa_contadores (limpa),
    .cont_palavras    (cp4),
    .cont_corrigidos  (cc4)
`ifdef HAMMING_SINDROME_SAIDA_EN
    ,
    .sindrome         (sind4),
    .cont_posicao_max (pmax4)
`endif
  );

  hamming_corretor #(.LARGURA_CONT(16)) dut16 (
    .clk              (clk),
    .rst_n            (rst_n),
    .entrada          (entrada),
    .entrada_valida   (entrada_valida),
    .entrada_pronta   (entrada_pronta16),
    .saida            (saida16),
    .corrigido        (corrigido16),
    .saida_valida     (saida_valida16),
    .saida_pronta     (saida_pronta),
    .limpa_contadores (limpa),
    .cont_palavras    (cp16),
    .cont_corrigidos  (cc16)
`ifdef HAMMING_SINDROME_SAIDA_EN
    ,
    .sindrome         (sind16),
    .cont_posicao_max (pmax16)
`endif
  );

  typedef struct packed { logic [10:0] s; logic c; } out_t;
  typedef struct packed { logic [14:0] w; logic [10:0] s; logic c; } rec_t;

  out_t        exp_q[$];
  rec_t        tbl[21];
  int          checks = 0;
  int          failures = 0;
  int          occ = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [10:0] prev_saida;
  logic        prev_corr;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nome, act, req);
    end
  endtask

  task automatic send(input rec_t r);
    int unsigned n;
    entrada        = r.w;
    entrada_valida = 1'b1;
    exp_q.push_back(out_t'{r.s, r.c});
    n = 0;
    @(negedge clk);
    while (!entrada_pronta && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!entrada_pronta) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=entrada_pronta=0 required=1");
    end
    @(posedge clk); #1;
    entrada_valida = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic clear();
    limpa = 1'b1;
    @(posedge clk); #1;
    limpa = 1'b0;
  endtask

  // Scoreboard, hold checker and occupancy model for entrada_pronta
  always @(negedge clk) begin
    out_t e;
    if (mon_en) begin
      chk("entrada_pronta", 32'(entrada_pronta), 32'(!(occ == 2 && !saida_pronta)));
      if (prev_stall) begin
        chk("hold_valid", 32'(saida_valida), 32'd1);
        chk("hold_saida", 32'(saida), 32'(prev_saida));
        chk("hold_corr", 32'(corrigido), 32'(prev_corr));
      end
      if (saida_valida && saida_pronta) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(saida_valida), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("saida", 32'(saida), 32'(e.s));
          chk("corrigido", 32'(corrigido), 32'(e.c));
        end
      end
      if (entrada_valida && entrada_pronta) occ++;
      if (saida_valida && saida_pronta) occ--;
      prev_stall = saida_valida && !saida_pronta;
      prev_saida = saida;
      prev_corr  = corrigido;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int ncorr;
    int unsigned n;

    // 11'h5A5 encodes to 15'h5A25 (data at 2,5,9,11,12,14; parity at bit 0)
    tbl[0] = rec_t'{15'h0000, 11'h000, 1'b0};
    tbl[1] = rec_t'{15'h7FFF, 11'h7FF, 1'b0};
    tbl[2] = rec_t'{15'h0040, 11'h000, 1'b1};
    tbl[3] = rec_t'{15'h4007, 11'h001, 1'b1};
    tbl[4] = rec_t'{15'h0007, 11'h001, 1'b0};
    tbl[5] = rec_t'{15'h5A25, 11'h5A5, 1'b0};
    for (int i = 0; i < 15; i++) begin
      tbl[6 + i] = rec_t'{15'h5A25 ^ (15'(1) << i), 11'h5A5, 1'b1};
    end

    rst_n = 1'b0; entrada = '0; entrada_valida = 1'b0; saida_pronta = 1'b1; limpa = 1'b0;
    #12;
    chk("rst_valid", 32'(saida_valida), 32'd0);
    chk("rst_saida", 32'(saida), 32'd0);
    chk("rst_corr", 32'(corrigido), 32'd0);
    chk("rst_cp", 32'(cp4), 32'd0);
    chk("rst_cc", 32'(cc4), 32'd0);
    chk("rst_pronta", 32'(entrada_pronta), 32'd1);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Clean words with explicit 2-cycle latency check
    entrada = 15'h0000; entrada_valida = 1'b1;
    exp_q.push_back(out_t'{11'h000, 1'b0});
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    @(negedge clk); chk("lat_c1_valid", 32'(saida_valida), 32'd0);
    @(negedge clk); chk("lat_c2_valid", 32'(saida_valida), 32'd1);
    @(posedge clk); #1;
    send(tbl[1]);
    drain();
    chk("clean_cp", 32'(cp4), 32'd2);
    chk("clean_cc", 32'(cc4), 32'd0);

    // Full table back-to-back, including the single-error sweep
    clear();
    chk("clear_cp16", 32'(cp16), 32'd0);
    ncorr = 0;
    for (int i = 0; i < 21; i++) begin
      send(tbl[i]);
      if (tbl[i].c) ncorr++;
    end
    drain();
    chk("tbl_cp16", 32'(cp16), 32'd21);
    chk("tbl_cc16", 32'(cc16), 32'(ncorr));
    chk("tbl_cp4_sat", 32'(cp4), 32'hF);
    chk("tbl_cc4_sat", 32'(cc4), 32'hF);

    // Backpressure 1,0,0,1 while streaming 8 words
    fork
      begin
        for (int i = 0; i < 8; i++) send(tbl[i + 2]);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          saida_pronta = ((i % 4) == 0) || ((i % 4) == 3);
          @(posedge clk); #1;
        end
      end
    join
    saida_pronta = 1'b1;
    drain();

    // Saturation, then clear coinciding with an output transfer
    clear();
    for (int i = 0; i < 20; i++) send(tbl[2]);
    drain();
    chk("sat_cp4", 32'(cp4), 32'hF);
    chk("sat_cc4", 32'(cc4), 32'hF);
    chk("sat_cp16", 32'(cp16), 32'd20);
    chk("sat_cc16", 32'(cc16), 32'd20);
    send(tbl[2]);
    n = 0;
    @(negedge clk);
    while (!saida_valida && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("limpa_xfer_valid", 32'(saida_valida), 32'd1);
    limpa = 1'b1;
    @(posedge clk); #1;
    limpa = 1'b0;
    chk("limpa_cp4", 32'(cp4), 32'd0);
    chk("limpa_cc4", 32'(cc4), 32'd0);
    chk("limpa_cp16", 32'(cp16), 32'd0);
    chk("limpa_cc16", 32'(cc16), 32'd0);

    // Reset with both stages occupied
    send(tbl[0]);
    drain();
    chk("pre_rst_cp", 32'(cp4), 32'd1);
    saida_pronta = 1'b0;
    send(tbl[2]);
    send(tbl[3]);
    @(negedge clk);
    chk("full_pronta", 32'(entrada_pronta), 32'd0);
    chk("full_valid", 32'(saida_valida), 32'd1);
    mon_en = 1'b0;
    exp_q.delete();
    occ = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(saida_valida), 32'd0);
    chk("midrst_saida", 32'(saida), 32'd0);
    chk("midrst_cp", 32'(cp4), 32'd0);
    chk("midrst_cc16", 32'(cc16), 32'd0);
    chk("midrst_pronta", 32'(entrada_pronta), 32'd1);
    saida_pronta = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(saida_valida), 32'd0);
    end
    chk("post_rst_cp", 32'(cp4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
